// File: rtl/serial_rx_framer.sv
// 12-bit async serial receiver (start, 8 data LSB first, parity, 2 stops) with mid-bit sampling.
// Latency: 2 + CLKS_PER_BIT/2 + 11*CLKS_PER_BIT + 1 cycles pin-to-strobe; no backpressure, data_valid is a one-cycle strobe.
module serial_rx_framer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clock,
   input  logic       preset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic ODD_MODE = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shift, shift_n;
   logic             perr_pend, perr_pend_n;
   logic             ferr_pend, ferr_pend_n;
   logic [7:0]       data_out_n;
   logic             data_valid_n, parity_err_n, frame_err_n, busy_n;
   logic             rx_m, rx_s, rx_prev;
   logic             tick;

   // Sync chain resets high so the line looks idle right after reset.
   always_ff @(posedge clock or negedge preset) begin
      if (!preset) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   assign tick = (cnt == '0);

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      bit_cnt_n    = bit_cnt;
      shift_n      = shift;
      perr_pend_n  = perr_pend;
      ferr_pend_n  = ferr_pend;
      data_out_n   = data_out;
      parity_err_n = parity_err;
      frame_err_n  = frame_err;
      data_valid_n = 1'b0;

      if (state != IDLE && !tick) begin
         cnt_n = cnt - 1'b1;
      end

      case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               state_n = START;
               cnt_n   = HALF_M1;
            end
         end
         START: begin
            if (tick) begin
               // A start bit that is high again at mid-bit was a glitch.
               if (!rx_s) begin
                  state_n     = DATA;
                  bit_cnt_n   = 3'd0;
                  cnt_n       = FULL_M1;
                  perr_pend_n = 1'b0;
                  ferr_pend_n = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_n[bit_cnt] = rx_s;
               cnt_n            = FULL_M1;
               bit_cnt_n        = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_n = PARITY;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               perr_pend_n = (^shift) ^ rx_s ^ ODD_MODE;
               cnt_n       = FULL_M1;
               state_n     = STOP1;
            end
         end
         STOP1: begin
            if (tick) begin
               if (!rx_s) begin
                  ferr_pend_n = 1'b1;
               end
               cnt_n   = FULL_M1;
               state_n = STOP2;
            end
         end
         STOP2: begin
            if (tick) begin
               data_out_n   = shift;
               parity_err_n = perr_pend;
               frame_err_n  = ferr_pend | ~rx_s;
               data_valid_n = 1'b1;
               state_n      = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE) | data_valid_n;
   end

   always_ff @(posedge clock or negedge preset) begin
      if (!preset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= 3'd0;
         shift      <= 8'h00;
         perr_pend  <= 1'b0;
         ferr_pend  <= 1'b0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         shift      <= shift_n;
         perr_pend  <= perr_pend_n;
         ferr_pend  <= ferr_pend_n;
         data_out   <= data_out_n;
         data_valid <= data_valid_n;
         parity_err <= parity_err_n;
         frame_err  <= frame_err_n;
         busy       <= busy_n;
      end
   end

endmodule
